eip_update_sequencer: RTL and testbench
=======================================

// Module: eip_update_sequencer
// PURPOSE
//   Sequences every EIP change in the CPU: sequential advance, jumps and interrupt vectoring.
//   Arbitrates three requesters, computes the target and drives the EIP register's write port
//   (read_or_write=4'h4 + write_data). Waits a settle window so fetch sees a stable EIP.
//   Sits between the decode/execute units and the EIP register, clocked on phase clock_4.
// PARAMETERS
//   RESET_EIP        32'h00000050  value EIP holds after reset (informational, exported on no port)
//   INT_BASE         32'h00000000  base address of interrupt vector table
//   INT_STRIDE_LOG2  2             log2 bytes per vector entry
//   SETTLE_CYCLES    2             clock_4 cycles held in SETTLE after each write (1..15)
//   MAX_OPE          6             largest legal instruction length in bytes
// PORTS
//   clock_4        in   1   sequencer clock
//   reset          in   1   asynchronous, active-high reset
//   eip            in   32  current EIP from the EIP register
//   fetch_busy     in   1   fetch in progress; blocks new grants while high
//   step_valid     in   1   instruction retired, advance EIP
//   step_len       in   4   retired instruction length in bytes
//   step_ack       out  1   one-cycle accept pulse for step request
//   jmp_valid      in   1   jump request
//   jmp_rel        in   1   1: target = eip + jmp_disp; 0: target = jmp_disp
//   jmp_disp       in   32  displacement or absolute target
//   jmp_ack        out  1   one-cycle accept pulse for jump request
//   int_valid      in   1   interrupt request
//   int_vec        in   8   interrupt vector number
//   int_ack        out  1   one-cycle accept pulse for interrupt request
//   read_or_write  out  4   EIP register select; 4'h4 during write cycle, else 4'h0
//   write_data     out  32  new EIP; valid while read_or_write==4'h4, else 0
//   upd_src        out  2   source of current/last update: 0 none, 1 step, 2 jmp, 3 int
//   busy           out  1   high in GRANT and SETTLE
//   err_len        out  1   sticky: a step with len 0 or > MAX_OPE was received
// BEHAVIOUR
//   Reset (async): state IDLE; all acks, read_or_write, write_data, upd_src, busy, err_len = 0.
//   FSM states: IDLE, GRANT, SETTLE. All outputs registered.
//   IDLE: if any valid && !fetch_busy, pick one by priority int > jmp > step, latch target, -> GRANT.
//     If fetch_busy, stay IDLE and ack nothing.
//   Target math (mod 2^32, eip sampled at the grant edge):
//     step: eip + step_len (zero-extended); int: INT_BASE + (int_vec << INT_STRIDE_LOG2);
//     jmp: jmp_rel ? eip + jmp_disp : jmp_disp. Wrap-around past 32'hFFFFFFFF is silent.
//   GRANT (exactly 1 cycle): winner's ack=1, read_or_write=4'h4, write_data=target, upd_src set,
//     busy=1; -> SETTLE. Write strobe appears 1 cycle after the request is sampled.
//   Illegal step (len 0 or > MAX_OPE): grant proceeds with step_ack=1, but read_or_write=4'h0,
//     write_data=0, and err_len is set (cleared only by reset).
//   SETTLE: busy=1, read_or_write=4'h0, SETTLE_CYCLES-cycle counter; at expiry -> IDLE.
//     fetch_busy is ignored in GRANT and SETTLE.
//   Handshake: requester holds valid + payload until it sees ack; it drops valid on the next edge.
//     Losing requesters get no ack and stay pending. No request is granted twice.
//   upd_src holds last value through SETTLE and IDLE until the next grant.
//   Reset mid-GRANT/SETTLE: write strobe drops immediately (async); pending update is discarded.
// TESTING
//   Reset: assert reset, check all outputs 0. Release, idle with no valid -> read_or_write stays 4'h0.
//   Step: eip=0x50, step_valid, len=3 -> next cycle step_ack=1, read_or_write=4'h4, write_data=0x53.
//   Priority: int_valid vec=5 + jmp_valid abs 0x100 same cycle -> int first, write 0x14;
//     after SETTLE_CYCLES, jmp granted and 0x100 written.
//   Rel jump/wrap: eip=0x50, jmp_rel=1, disp=0xFFFFFFFE -> 0x4E; eip=0xFFFFFFFE, step len 4 -> 0x2.
//   Illegal len: step len 7 -> step_ack=1, no write strobe, err_len=1 and stays 1.
//   fetch_busy/reset: valid while fetch_busy=1 -> no ack. Reset in SETTLE -> IDLE, outputs 0, no write.

Source files
------------

// File: rtl/eip_update_sequencer.sv
// EIP update sequencer.
// Arbitrates the step, jump and interrupt requesters and drives the EIP register's write port.
// Each accepted request produces a one-cycle write strobe (GRANT), followed by a settle
// window (SETTLE) so that fetch sees a stable EIP before the next update is accepted.
module eip_update_sequencer #(
    parameter logic [31:0] RESET_EIP       = 32'h0000_0050,
    parameter logic [31:0] INT_BASE        = 32'h0000_0000,
    parameter int unsigned INT_STRIDE_LOG2 = 2,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned MAX_OPE         = 6
) (
    input  logic        clock_4,
    input  logic        reset,
    input  logic [31:0] eip,
    input  logic        fetch_busy,
    input  logic        step_valid,
    input  logic [3:0]  step_len,
    output logic        step_ack,
    input  logic        jmp_valid,
    input  logic        jmp_rel,
    input  logic [31:0] jmp_disp,
    output logic        jmp_ack,
    input  logic        int_valid,
    input  logic [7:0]  int_vec,
    output logic        int_ack,
    output logic [3:0]  read_or_write,
    output logic [31:0] write_data,
    output logic [1:0]  upd_src,
    output logic        busy,
    output logic        err_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] RW_WRITE    = 4'h4;
    localparam logic [3:0] RW_NONE     = 4'h0;
    localparam logic [3:0] MAX_LEN     = 4'(MAX_OPE);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    localparam logic [1:0] SRC_STEP = 2'd1;
    localparam logic [1:0] SRC_JMP  = 2'd2;
    localparam logic [1:0] SRC_INT  = 2'd3;

    // The reset value of EIP lives in the EIP register itself; it is kept here for reference only.
    logic unused_reset_eip;
    assign unused_reset_eip = ^RESET_EIP;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        step_ack_nxt, jmp_ack_nxt, int_ack_nxt;
    logic [3:0]  rw_nxt;
    logic [31:0] wd_nxt;
    logic [1:0]  src_nxt;
    logic        busy_nxt, err_nxt;

    // Candidate targets, evaluated against the eip present at the grant edge.
    logic [31:0] step_target, jmp_target, int_target;
    logic        step_illegal;

    assign step_target  = eip + {28'd0, step_len};
    assign jmp_target   = jmp_rel ? (eip + jmp_disp) : jmp_disp;
    assign int_target   = INT_BASE + ({24'd0, int_vec} << INT_STRIDE_LOG2);
    assign step_illegal = (step_len == 4'd0) || (step_len > MAX_LEN);

    // State, settle counter and every output are registered together.
    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            step_ack      <= 1'b0;
            jmp_ack       <= 1'b0;
            int_ack       <= 1'b0;
            read_or_write <= RW_NONE;
            write_data    <= 32'd0;
            upd_src       <= 2'd0;
            busy          <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            step_ack      <= step_ack_nxt;
            jmp_ack       <= jmp_ack_nxt;
            int_ack       <= int_ack_nxt;
            read_or_write <= rw_nxt;
            write_data    <= wd_nxt;
            upd_src       <= src_nxt;
            busy          <= busy_nxt;
            err_len       <= err_nxt;
        end
    end

    // Next-state and next-output logic; acks and the write strobe default low every cycle.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        step_ack_nxt = 1'b0;
        jmp_ack_nxt  = 1'b0;
        int_ack_nxt  = 1'b0;
        rw_nxt       = RW_NONE;
        wd_nxt       = 32'd0;
        src_nxt      = upd_src;
        busy_nxt     = busy;
        err_nxt      = err_len;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (!fetch_busy && (int_valid || jmp_valid || step_valid)) begin
                    state_nxt = GRANT;
                    busy_nxt  = 1'b1;
                    if (int_valid) begin
                        int_ack_nxt = 1'b1;
                        rw_nxt      = RW_WRITE;
                        wd_nxt      = int_target;
                        src_nxt     = SRC_INT;
                    end else if (jmp_valid) begin
                        jmp_ack_nxt = 1'b1;
                        rw_nxt      = RW_WRITE;
                        wd_nxt      = jmp_target;
                        src_nxt     = SRC_JMP;
                    end else begin
                        // An illegal length is still acked so the requester is released,
                        // but EIP is left untouched and the error is latched.
                        step_ack_nxt = 1'b1;
                        src_nxt      = SRC_STEP;
                        if (step_illegal) begin
                            err_nxt = 1'b1;
                        end else begin
                            rw_nxt = RW_WRITE;
                            wd_nxt = step_target;
                        end
                    end
                end
            end
            GRANT: begin
                state_nxt = SETTLE;
                busy_nxt  = 1'b1;
                cnt_nxt   = SETTLE_LOAD;
            end
            SETTLE: begin
                busy_nxt = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_eip_update_sequencer.sv
// Directed bench for eip_update_sequencer with a grant scoreboard.
// Expected grants are queued as requests are driven; a monitor pops and compares on every ack.
module tb_eip_update_sequencer;

    localparam int SETTLE = 2;

    logic        clock_4 = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] eip     = 32'h50;
    logic        fetch_busy = 1'b0;
    logic        step_valid = 1'b0;
    logic [3:0]  step_len   = 4'd0;
    logic        step_ack;
    logic        jmp_valid = 1'b0;
    logic        jmp_rel   = 1'b0;
    logic [31:0] jmp_disp  = 32'd0;
    logic        jmp_ack;
    logic        int_valid = 1'b0;
    logic [7:0]  int_vec   = 8'd0;
    logic        int_ack;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic [1:0]  upd_src;
    logic        busy;
    logic        err_len;

    eip_update_sequencer #(
        .RESET_EIP(32'h50), .INT_BASE(32'h0), .INT_STRIDE_LOG2(2),
        .SETTLE_CYCLES(SETTLE), .MAX_OPE(6)
    ) dut (
        .clock_4(clock_4), .reset(reset), .eip(eip), .fetch_busy(fetch_busy),
        .step_valid(step_valid), .step_len(step_len), .step_ack(step_ack),
        .jmp_valid(jmp_valid), .jmp_rel(jmp_rel), .jmp_disp(jmp_disp), .jmp_ack(jmp_ack),
        .int_valid(int_valid), .int_vec(int_vec), .int_ack(int_ack),
        .read_or_write(read_or_write), .write_data(write_data), .upd_src(upd_src),
        .busy(busy), .err_len(err_len)
    );

    always #5 clock_4 = ~clock_4;

    typedef struct packed {
        logic [2:0]  acks;   // {int, jmp, step}
        logic [3:0]  rw;
        logic [31:0] wd;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] acks, input logic [3:0] rw,
                                input logic [31:0] wd, input logic [1:0] src);
        exp_t e;
        e.acks = acks; e.rw = rw; e.wd = wd; e.src = src;
        return e;
    endfunction

    // Scoreboard monitor: every ack must match the oldest queued expectation.
    always @(posedge clock_4) begin
        exp_t e;
        #1;
        if ({int_ack, jmp_ack, step_ack} != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {61'd0, int_ack, jmp_ack, step_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("grant", {23'd0, int_ack, jmp_ack, step_ack, read_or_write, write_data, upd_src},
                    {23'd0, e});
            end
        end
    end

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clock_4); #1; n++;
        end while (!(int_ack | jmp_ack | step_ack) && n < 20);
        chk({tag, "_ack_seen"}, {63'd0, (int_ack | jmp_ack | step_ack)}, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock_4); n++;
        end while (busy && n < 20);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #2;
        chk("reset_outputs", {21'd0, step_ack, jmp_ack, int_ack, read_or_write, write_data,
                              upd_src, busy, err_len}, 64'd0);
        repeat (2) @(negedge clock_4);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock_4); #1;
            chk("idle_rw", {60'd0, read_or_write}, 64'd0);
        end

        // Sequential step: 0x50 + 3, strobe one cycle after sampling, then exact settle length
        @(negedge clock_4);
        eip = 32'h50; step_len = 4'd3; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h50 + 32'd3, 2'd1));
        wait_ack("step", n);
        chk("step_latency", 64'(n), 64'd1);
        @(negedge clock_4); step_valid = 1'b0;
        @(posedge clock_4); #1;
        chk("settle_out", {27'd0, busy, read_or_write, write_data}, {27'd0, 1'b1, 4'h0, 32'h0});
        chk("src_hold", {62'd0, upd_src}, 64'd1);
        repeat (SETTLE - 1) begin
            @(posedge clock_4); #1;
            chk("settle_busy", {63'd0, busy}, 64'd1);
        end
        @(posedge clock_4); #1;
        chk("settle_done", {63'd0, busy}, 64'd0);
        chk("src_hold_idle", {62'd0, upd_src}, 64'd1);

        // Priority: interrupt beats jump; jump follows after the settle window
        @(negedge clock_4);
        int_vec = 8'd5; int_valid = 1'b1;
        jmp_rel = 1'b0; jmp_disp = 32'h100; jmp_valid = 1'b1;
        sb.push_back(mk(3'b100, 4'h4, 32'd5 << 2, 2'd3));
        sb.push_back(mk(3'b010, 4'h4, 32'h100, 2'd2));
        wait_ack("int", n);
        @(negedge clock_4); int_valid = 1'b0;
        wait_ack("jmp", n);
        chk("jmp_gap", 64'(n), 64'(SETTLE + 2));
        @(negedge clock_4); jmp_valid = 1'b0;
        wait_idle("prio");

        // Relative jump wrapping below zero
        eip = 32'h50; jmp_rel = 1'b1; jmp_disp = 32'hFFFF_FFFE; jmp_valid = 1'b1;
        sb.push_back(mk(3'b010, 4'h4, 32'h50 + 32'hFFFF_FFFE, 2'd2));
        wait_ack("rel", n);
        @(negedge clock_4); jmp_valid = 1'b0;
        wait_idle("rel");

        // Step wrapping past the top of the address space
        eip = 32'hFFFF_FFFE; step_len = 4'd4; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h2, 2'd1));
        wait_ack("wrap", n);
        @(negedge clock_4); step_valid = 1'b0;
        wait_idle("wrap");

        // Largest legal length
        eip = 32'h50; step_len = 4'd6; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h56, 2'd1));
        wait_ack("len6", n);
        chk("len6_no_err", {63'd0, err_len}, 64'd0);
        @(negedge clock_4); step_valid = 1'b0;
        wait_idle("len6");

        // Illegal length: acked, no strobe, sticky error
        step_len = 4'd7; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h0, 32'h0, 2'd1));
        wait_ack("len7", n);
        chk("err_set", {63'd0, err_len}, 64'd1);
        @(negedge clock_4); step_valid = 1'b0;
        wait_idle("len7");
        step_len = 4'd1; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h51, 2'd1));
        wait_ack("after_err", n);
        @(negedge clock_4); step_valid = 1'b0;
        wait_idle("after_err");
        chk("err_sticky", {63'd0, err_len}, 64'd1);

        // fetch_busy blocks grants
        fetch_busy = 1'b1; eip = 32'h60; step_len = 4'd2; step_valid = 1'b1;
        repeat (3) begin
            @(posedge clock_4); #1;
            chk("fb_no_ack", {61'd0, int_ack, jmp_ack, step_ack}, 64'd0);
        end
        @(negedge clock_4); fetch_busy = 1'b0;
        sb.push_back(mk(3'b001, 4'h4, 32'h62, 2'd1));
        wait_ack("fb_release", n);
        chk("fb_latency", 64'(n), 64'd1);
        @(negedge clock_4); step_valid = 1'b0;
        wait_idle("fb");

        // Reset during SETTLE
        eip = 32'h70; step_len = 4'd1; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h71, 2'd1));
        wait_ack("rst_settle", n);
        @(negedge clock_4); step_valid = 1'b0;
        @(posedge clock_4); #1;
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset_settle_outputs", {21'd0, step_ack, jmp_ack, int_ack, read_or_write, write_data,
                                     upd_src, busy, err_len}, 64'd0);
        @(negedge clock_4); reset = 1'b0;
        repeat (3) begin
            @(posedge clock_4); #1;
            chk("post_reset_quiet", {59'd0, read_or_write, busy}, 64'd0);
        end

        // Reset during GRANT drops the strobe asynchronously
        @(negedge clock_4);
        eip = 32'h80; step_len = 4'd2; step_valid = 1'b1;
        sb.push_back(mk(3'b001, 4'h4, 32'h82, 2'd1));
        wait_ack("rst_grant", n);
        #2 reset = 1'b1; step_valid = 1'b0;
        #1;
        chk("reset_grant_strobe", {28'd0, read_or_write, write_data}, 64'd0);
        @(negedge clock_4); reset = 1'b0;
        repeat (2) begin
            @(posedge clock_4); #1;
            chk("post_grant_reset_quiet", {59'd0, read_or_write, busy}, 64'd0);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
